cardrom_loader_arb: RTL
=======================

// Module: cardrom_loader_arb
// PURPOSE
//   Fills the 2 KB card-ROM BRAM from a byte stream (SoC/flash) after boot, then raises
//   req_rom_release_o to the card-ROM slave. Owns the single BRAM port and arbitrates
//   between Apple II bus reads ($F800-$FFFF window) and loader writes. Bus reads always win.
// PARAMETERS
//   ROM_DEPTH   2048  bytes in card-ROM image; load_len_i legal range 1..ROM_DEPTH
//   ADDR_WIDTH  11    BRAM address width; must equal clog2(ROM_DEPTH)
// PORTS
//   clk_logic          in   1   logic clock, single clock domain
//   system_reset_n     in   1   synchronous, active-low reset
//   load_start_i       in   1   1-cycle pulse: begin load of load_len_i bytes
//   load_len_i         in   12  byte count, sampled on load_start_i
//   src_valid_i        in   1   stream byte valid
//   src_data_i         in   8   stream byte
//   src_ready_o        out  1   byte accepted when src_valid_i && src_ready_o
//   bus_rd_req_i       in   1   bus read of card ROM (phi0 && F8 window && rw_n)
//   bus_addr_i         in   11  bus address [10:0]
//   bus_data_o         out  8   byte returned to bus
//   rom_addr_o         out  11  BRAM address
//   rom_we_o           out  1   BRAM write enable
//   rom_wdata_o        out  8   BRAM write data
//   rom_rdata_i        in   8   BRAM read data, 1-cycle registered latency
//   busy_o             out  1   state == LOAD or CHECK
//   done_o             out  1   state == DONE
//   error_o            out  1   state == ERROR
//   req_rom_release_o  out  1   image valid; sticky until reset
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; byte counter, write addr, checksum cleared.
//   States: IDLE -> LOAD on load_start_i with 1 <= load_len_i <= ROM_DEPTH;
//     IDLE -> ERROR on load_start_i with load_len_i == 0 or > ROM_DEPTH;
//     LOAD -> DONE (or CHECK, see CONFIGURATION) when final byte accepted;
//     ERROR -> LOAD/ERROR on new load_start_i (same length checks); DONE is terminal.
//   load_start_i ignored in LOAD, CHECK, DONE.
//   src_ready_o = (state == LOAD) && !bus_rd_req_i (combinational).
//   Accepted byte: rom_we_o=1, rom_addr_o=write addr, rom_wdata_o=src_data_i same cycle;
//     write addr starts at 0, +1 per accepted byte, never wraps (length bounded).
//   Arbitration: bus_rd_req_i=1 -> rom_addr_o=bus_addr_i, rom_we_o=0, loader stalls; a
//     byte held valid during a bus read is taken on the first cycle with bus_rd_req_i=0.
//   Bus read latency: bus_data_o registers rom_rdata_i on the cycle after each bus_rd_req_i
//     cycle, i.e. valid 2 cycles after bus_addr_i presented; holds last value otherwise.
//   Bus reads serviced in every state (pre-load data undefined, no X on bus_data_o after
//     first read).
//   req_rom_release_o asserts the cycle state enters DONE; held until reset.
//   Reset mid-load: return to IDLE next edge; partial image left in BRAM; release stays 0.
// CONFIGURATION
//   CARDROM_CHECKSUM_EN defined: last stream byte is an 8-bit checksum, not written;
//     first load_len_i-1 bytes written, running sum mod 256 accumulated; on last byte
//     enter CHECK for 1 cycle: match -> DONE, mismatch -> ERROR. load_len_i must be >= 2
//     (len 1 -> ERROR).
//   Not defined: all load_len_i bytes written; LOAD -> DONE directly, CHECK never entered.
// TESTING
//   Reset, load_start len=2048, stream 0x00..0xFF repeating, no bus traffic -> 2048 writes
//     at addr 0..2047, done_o and req_rom_release_o rise together after last byte.
//   Load len=4 with bus_rd_req_i held 3 cycles mid-stream -> src_ready_o=0 those cycles,
//     rom_we_o=0, bytes land at addrs 0..3 unchanged, bus_data_o = BRAM[bus_addr_i] 2 cycles on.
//   load_start len=0, then len=3000 -> error_o=1, no writes; then len=16 -> LOAD, done_o.
//   CARDROM_CHECKSUM_EN: len=4, bytes 01 02 03 06 -> 3 writes, DONE; bytes 01 02 03 07 -> ERROR.
//   Reset asserted at byte 100 of 2048 -> IDLE, busy_o=0, release 0; fresh load completes.
//   load_start_i pulsed during LOAD and in DONE -> ignored; counters and release unaffected.

Source files
------------

// File: rtl/cardrom_loader_arb_if.sv
// Bundles the loader control, byte stream, Apple II bus read port, BRAM port
// and status lines of cardrom_loader_arb. The slave modport is the loader's view.
//
// Stream handshake: a byte moves on a rising clock edge exactly when
// src_valid_i && src_ready_o are both high in the cycle before that edge.
// The source holds src_valid_i and src_data_i stable until the byte moves.
// src_ready_o may drop at any time, for example while the bus owns the BRAM port.
interface cardrom_loader_arb_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 12
);
  logic                  load_start_i;
  logic [LEN_WIDTH-1:0]  load_len_i;
  logic                  src_valid_i;
  logic [7:0]            src_data_i;
  logic                  src_ready_o;
  logic                  bus_rd_req_i;
  logic [ADDR_WIDTH-1:0] bus_addr_i;
  logic [7:0]            bus_data_o;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic                  rom_we_o;
  logic [7:0]            rom_wdata_o;
  logic [7:0]            rom_rdata_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic                  req_rom_release_o;
  logic [2:0]            dbg_state_o;   // FSM state encoding, for debug and checkers

  modport slave (
    input  load_start_i, load_len_i, src_valid_i, src_data_i,
           bus_rd_req_i, bus_addr_i, rom_rdata_i,
    output src_ready_o, bus_data_o, rom_addr_o, rom_we_o, rom_wdata_o,
           busy_o, done_o, error_o, req_rom_release_o, dbg_state_o
  );

  modport master (
    output load_start_i, load_len_i, src_valid_i, src_data_i,
           bus_rd_req_i, bus_addr_i, rom_rdata_i,
    input  src_ready_o, bus_data_o, rom_addr_o, rom_we_o, rom_wdata_o,
           busy_o, done_o, error_o, req_rom_release_o, dbg_state_o
  );
endinterface

// File: rtl/cardrom_loader_arb.sv
// Card-ROM loader and BRAM port arbiter.
// Fills the card-ROM BRAM from a byte stream after boot, then raises
// req_rom_release_o (sticky until reset). Apple II bus reads always own the
// single BRAM port; the loader stalls while a bus read is in progress.
// Optional feature macro: CARDROM_CHECKSUM_EN -- the last stream byte is an
// 8-bit additive checksum of the preceding bytes and is not written.
module cardrom_loader_arb #(
  parameter int ROM_DEPTH  = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input  logic clk_logic,
  input  logic system_reset_n,
  cardrom_loader_arb_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [12:0] DEPTH_L = 13'(ROM_DEPTH);
`ifdef CARDROM_CHECKSUM_EN
  localparam logic [11:0] MIN_LEN = 12'd2;  // need at least one payload byte plus checksum
`else
  localparam logic [11:0] MIN_LEN = 12'd1;
`endif

  state_t      state, state_n;
  logic [11:0] byte_cnt;     // bytes accepted so far; low bits are the write address
  logic [11:0] len_q;        // length captured at load start
  logic        release_q;
  logic        bus_rd_q;     // a bus read was issued last cycle, BRAM data is ready now
  logic [7:0]  bus_data_q;
`ifdef CARDROM_CHECKSUM_EN
  logic [7:0]  sum_q;        // running sum mod 256 of payload bytes
  logic [7:0]  chk_q;        // checksum byte received at the end of the stream
`endif

  logic len_ok;
  logic start_ok;
  logic accept;
  logic last_byte;

  // FSM state register
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) state <= S_IDLE;
    else                 state <= state_n;
  end

  // Next-state, arbitration and status decode
  always_comb begin
    state_n        = state;
    len_ok         = (io.load_len_i >= MIN_LEN) && ({1'b0, io.load_len_i} <= DEPTH_L);
    start_ok       = 1'b0;
    last_byte      = (byte_cnt == (len_q - 12'd1));
    io.src_ready_o = (state == S_LOAD) && !io.bus_rd_req_i;
    accept         = io.src_ready_o && io.src_valid_i;
    io.rom_addr_o  = byte_cnt[ADDR_WIDTH-1:0];
    io.rom_we_o    = 1'b0;
    io.rom_wdata_o = io.src_data_i;

    // The bus owns the port whenever it asks; src_ready_o is already low then.
    if (io.bus_rd_req_i) io.rom_addr_o = io.bus_addr_i;

`ifdef CARDROM_CHECKSUM_EN
    io.rom_we_o = accept && !last_byte;
`else
    io.rom_we_o = accept;
`endif

    case (state)
      S_IDLE, S_ERROR: begin
        if (io.load_start_i) begin
          start_ok = len_ok;
          state_n  = len_ok ? S_LOAD : S_ERROR;
        end
      end
      S_LOAD: begin
        if (accept && last_byte) begin
`ifdef CARDROM_CHECKSUM_EN
          state_n = S_CHECK;
`else
          state_n = S_DONE;
`endif
        end
      end
      S_CHECK: begin
`ifdef CARDROM_CHECKSUM_EN
        state_n = (sum_q == chk_q) ? S_DONE : S_ERROR;
`else
        state_n = S_IDLE;
`endif
      end
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase

    io.busy_o            = (state == S_LOAD) || (state == S_CHECK);
    io.done_o            = (state == S_DONE);
    io.error_o           = (state == S_ERROR);
    io.req_rom_release_o = release_q;
    io.bus_data_o        = bus_data_q;
    io.dbg_state_o       = state;
  end

  // Byte counter, checksum, release flag and bus read data register
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      byte_cnt   <= '0;
      len_q      <= '0;
      release_q  <= 1'b0;
      bus_rd_q   <= 1'b0;
      bus_data_q <= '0;
`ifdef CARDROM_CHECKSUM_EN
      sum_q      <= '0;
      chk_q      <= '0;
`endif
    end else begin
      if (start_ok) begin
        byte_cnt <= '0;
        len_q    <= io.load_len_i;
`ifdef CARDROM_CHECKSUM_EN
        sum_q    <= '0;
`endif
      end else if (accept) begin
        byte_cnt <= byte_cnt + 12'd1;
`ifdef CARDROM_CHECKSUM_EN
        if (last_byte) chk_q <= io.src_data_i;
        else           sum_q <= sum_q + io.src_data_i;
`endif
      end
      if (state_n == S_DONE) release_q <= 1'b1;
      bus_rd_q <= io.bus_rd_req_i;
      if (bus_rd_q) bus_data_q <= io.rom_rdata_i;
    end
  end

endmodule
